// File: rtl/grid_pkg.sv
// Shared types and constants for the playfield grid writer and its row-shift helper.
package grid_pkg;
    localparam int ROWS = 20;
    localparam int COLS = 10;

    typedef logic [4:0]      row_t;
    typedef logic [3:0]      col_t;
    typedef logic [1:COLS]   row_bits_t;

    typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, DONE} state_t;

    localparam logic [19:0] SCORE_1   = 20'd40;
    localparam logic [19:0] SCORE_2   = 20'd100;
    localparam logic [19:0] SCORE_3   = 20'd300;
    localparam logic [19:0] SCORE_4   = 20'd1200;
    localparam logic [19:0] SCORE_MAX = 20'hFFFFF;

    function automatic logic [19:0] score_for(input logic [2:0] n);
        case (n)
            3'd1:    return SCORE_1;
            3'd2:    return SCORE_2;
            3'd3:    return SCORE_3;
            3'd4:    return SCORE_4;
            default: return 20'd0;
        endcase
    endfunction
endpackage

// File: rtl/grid_row_shift.sv
// Removes row r from the grid: rows above r drop by one and row 1 becomes empty.
module grid_row_shift
    import grid_pkg::*;
(
    input  row_bits_t grid_in  [1:ROWS],
    input  row_t      r,
    output row_bits_t grid_out [1:ROWS]
);
    always_comb begin
        for (int k = 1; k <= ROWS; k++) begin
            if (row_t'(k) > r)
                grid_out[k] = grid_in[k];
            else if (k == 1)
                grid_out[k] = '0;
            else
                grid_out[k] = grid_in[k-1];
        end
    end
endmodule

// File: rtl/grid_writer.sv
// Playfield grid writer: locks a piece into the grid, then clears full rows bottom-up.
// Optional scoring is built only when GRID_WRITER_SCORE_EN is defined.
//   state | meaning
//   IDLE  | waiting for a lock request or grid clear
//   WRITE | OR the four captured cells into the grid
//   SCAN  | test row scan_r for full, walking upward
//   SHIFT | remove row scan_r, rescan the same index
//   DONE  | one-cycle completion pulse
module grid_writer
    import grid_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lock_valid,
    output logic        lock_ready,
    input  row_t        cell_row [0:3],
    input  col_t        cell_col [0:3],
    input  logic        clear_grid,
    output row_bits_t   grid [1:ROWS],
    output logic        busy,
    output logic        done,
    output logic [2:0]  lines_cleared,
    output logic [19:0] score
);
    state_t    state, state_nxt;
    row_t      row_q [0:3];
    col_t      col_q [0:3];
    row_t      scan_r;
    logic [2:0] count;
    row_bits_t grid_wr [1:ROWS];
    row_bits_t grid_sh [1:ROWS];
    logic      accept, row_full, wipe, enter_done;

    assign accept     = lock_valid && lock_ready;
    assign row_full   = &grid[scan_r];
    assign wipe       = (state == IDLE) && clear_grid;
    assign enter_done = (state == SCAN) && !row_full && (scan_r == 5'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = WRITE;
            WRITE:   state_nxt = SCAN;
            SCAN: begin
                if (row_full)            state_nxt = SHIFT;
                else if (scan_r == 5'd1) state_nxt = DONE;
            end
            SHIFT:   state_nxt = SCAN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lock_ready = (state == IDLE) && !clear_grid;
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

    // Out-of-range cells are skipped individually; the rest still land.
    always_comb begin
        grid_wr = grid;
        for (int i = 0; i < 4; i++) begin
            if (row_q[i] >= 5'd1 && row_q[i] <= 5'(ROWS) &&
                col_q[i] >= 4'd1 && col_q[i] <= 4'(COLS))
                grid_wr[row_q[i]][col_q[i]] = 1'b1;
        end
    end

    grid_row_shift u_shift (
        .grid_in  (grid),
        .r        (scan_r),
        .grid_out (grid_sh)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q         <= '{default: '0};
            col_q         <= '{default: '0};
            scan_r        <= 5'(ROWS);
            count         <= 3'd0;
            lines_cleared <= 3'd0;
        end else begin
            if (accept) begin
                row_q <= cell_row;
                col_q <= cell_col;
            end
            case (state)
                WRITE: begin
                    scan_r <= 5'(ROWS);
                    count  <= 3'd0;
                end
                SCAN:  if (!row_full && scan_r != 5'd1) scan_r <= scan_r - 5'd1;
                SHIFT: if (count != 3'd4) count <= count + 3'd1;
                default: ;
            endcase
            // Latched on the way into DONE so it is already valid while done is high.
            if (enter_done) lines_cleared <= count;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              grid <= '{default: '0};
        else if (wipe)             grid <= '{default: '0};
        else if (state == WRITE)   grid <= grid_wr;
        else if (state == SHIFT)   grid <= grid_sh;
    end

`ifdef GRID_WRITER_SCORE_EN
    logic [20:0] score_sum;
    assign score_sum = {1'b0, score} + {1'b0, score_for(count)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        score <= 20'd0;
        else if (wipe)       score <= 20'd0;
        else if (enter_done) score <= score_sum[20] ? SCORE_MAX : score_sum[19:0];
    end
`else
    assign score = 20'd0;
`endif
endmodule

// File: tb/tb_grid_writer.sv
// Directed and random lock sequences against a row-list model of the playfield.
module tb_grid_writer;
    import grid_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        lock_valid = 1'b0;
    logic        clear_grid = 1'b0;
    logic        lock_ready, busy, done;
    logic [2:0]  lines_cleared;
    logic [19:0] score;
    row_t        cell_row [0:3];
    col_t        cell_col [0:3];
    row_bits_t   grid [1:ROWS];

    int n_cmp = 0;
    int n_err = 0;
    bit m [1:20][1:10];
    int exp_score = 0;
    int lr [4];
    int lc [4];

    always #5 clk = ~clk;

    grid_writer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lock_valid    (lock_valid),
        .lock_ready    (lock_ready),
        .cell_row      (cell_row),
        .cell_col      (cell_col),
        .clear_grid    (clear_grid),
        .grid          (grid),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .score         (score)
    );

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [199:0] dut_flat();
        logic [199:0] f = '0;
        for (int r = 1; r <= 20; r++)
            for (int c = 1; c <= 10; c++)
                f[(r-1)*10 + c-1] = grid[r][c];
        return f;
    endfunction

    function automatic logic [199:0] model_flat();
        logic [199:0] f = '0;
        for (int r = 1; r <= 20; r++)
            for (int c = 1; c <= 10; c++)
                f[(r-1)*10 + c-1] = m[r][c];
        return f;
    endfunction

    task automatic model_clear();
        for (int r = 1; r <= 20; r++)
            for (int c = 1; c <= 10; c++)
                m[r][c] = 0;
    endtask

    // Drop in the cells, then keep only non-full rows, stacked from the bottom.
    task automatic model_lock(output int k);
        bit nm [1:20][1:10];
        int dst;
        bit full;
        for (int i = 0; i < 4; i++)
            if (lr[i] >= 1 && lr[i] <= 20 && lc[i] >= 1 && lc[i] <= 10)
                m[lr[i]][lc[i]] = 1;
        for (int r = 1; r <= 20; r++)
            for (int c = 1; c <= 10; c++)
                nm[r][c] = 0;
        k = 0;
        dst = 20;
        for (int r = 20; r >= 1; r--) begin
            full = 1;
            for (int c = 1; c <= 10; c++)
                if (!m[r][c]) full = 0;
            if (full) k++;
            else begin
                for (int c = 1; c <= 10; c++) nm[dst][c] = m[r][c];
                dst--;
            end
        end
        for (int r = 1; r <= 20; r++)
            for (int c = 1; c <= 10; c++)
                m[r][c] = nm[r][c];
    endtask

    task automatic setc(input int r0, c0, r1, c1, r2, c2, r3, c3);
        lr[0] = r0; lc[0] = c0; lr[1] = r1; lc[1] = c1;
        lr[2] = r2; lc[2] = c2; lr[3] = r3; lc[3] = c3;
    endtask

    task automatic drive_cells();
        for (int i = 0; i < 4; i++) begin
            cell_row[i] = row_t'(lr[i]);
            cell_col[i] = col_t'(lc[i]);
        end
    endtask

    task automatic do_lock(input string tag);
        int k;
        int cyc;
        int pts;
        @(negedge clk);
        drive_cells();
        lock_valid = 1'b1;
        #1;
        chk({tag, "_ready"}, lock_ready, 1);
        @(posedge clk);
        #1;
        lock_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cell_row[i] = '0;
            cell_col[i] = '0;
        end
        model_lock(k);
        case (k)
            0: pts = 0;
            1: pts = 40;
            2: pts = 100;
            3: pts = 300;
            default: pts = 1200;
        endcase
`ifdef GRID_WRITER_SCORE_EN
        exp_score = exp_score + pts;
        if (exp_score > 20'hFFFFF) exp_score = 20'hFFFFF;
`else
        exp_score = 0;
`endif
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({tag, "_busy"}, busy, 1);
        end while (!done && cyc < 60);
        chk({tag, "_latency"}, cyc, 22 + 2*k);
        chk({tag, "_lines"}, lines_cleared, k);
        chk({tag, "_grid"}, dut_flat(), model_flat());
        chk({tag, "_score"}, score, exp_score);
        @(negedge clk);
        chk({tag, "_pulse"}, {done, lock_ready}, 2'b01);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 4; i++) begin
            cell_row[i] = '0;
            cell_col[i] = '0;
        end
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Preload, then reset asynchronously while the grid is non-empty.
        setc(5, 5, 6, 6, 7, 7, 1, 1);
        do_lock("pre");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_grid", dut_flat(), 0);
        chk("rst_ready", lock_ready, 1);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_lines_score", {lines_cleared, score}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        exp_score = 0;

        setc(20, 1, 20, 2, 19, 1, 19, 2);
        do_lock("square");
        chk("square_row20", grid[20], 10'b1100000000);

        setc(20, 3, 20, 4, 20, 5, 20, 6);
        do_lock("fill6");
        setc(20, 7, 20, 8, 20, 9, 20, 10);
        do_lock("line1");
        chk("line1_row20", grid[20], 10'b1100000000);
        chk("line1_row1", grid[1], 0);

        // clear_grid wins over a simultaneous lock request.
        @(negedge clk);
        setc(20, 1, 20, 2, 20, 3, 20, 4);
        drive_cells();
        clear_grid = 1'b1;
        lock_valid = 1'b1;
        #1;
        chk("clr_ready", lock_ready, 0);
        @(posedge clk);
        #1;
        clear_grid = 1'b0;
        lock_valid = 1'b0;
        chk("clr_grid", dut_flat(), 0);
        model_clear();
        exp_score = 0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            seen |= done | busy;
        end
        chk("clr_no_seq", seen, 0);

        for (int r = 17; r <= 20; r++) begin
            setc(r, 1, r, 2, r, 3, r, 4);
            do_lock("stack_a");
            setc(r, 5, r, 6, r, 7, r, 8);
            do_lock("stack_b");
        end
        setc(17, 9, 18, 9, 19, 9, 20, 9);
        do_lock("stack_c");
        setc(17, 10, 18, 10, 19, 10, 20, 10);
        do_lock("tetris");
        chk("tetris_empty", dut_flat(), 0);
`ifdef GRID_WRITER_SCORE_EN
        chk("tetris_score", score, 1200);
`else
        chk("tetris_score", score, 0);
`endif

        setc(0, 3, 21, 11, 10, 4, 11, 5);
        do_lock("oob");
        chk("oob_row10", grid[10], 10'b0001000000);
        chk("oob_row11", grid[11], 10'b0000100000);

        // Abort in the middle of a row removal.
        setc(20, 1, 20, 2, 20, 3, 20, 4);
        do_lock("pre_shift_a");
        setc(20, 5, 20, 6, 20, 7, 20, 8);
        do_lock("pre_shift_b");
        @(negedge clk);
        setc(20, 9, 20, 10, 20, 9, 20, 10);
        drive_cells();
        lock_valid = 1'b1;
        @(posedge clk);
        #1;
        lock_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("shift_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("shift_rst_grid", dut_flat(), 0);
        chk("shift_rst_ready", lock_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        exp_score = 0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            seen |= done;
        end
        chk("shift_rst_nodone", seen, 0);
        chk("shift_rst_ready2", lock_ready, 1);

        setc(20, 1, 20, 2, 20, 3, 20, 4);
        do_lock("gap_a");
        setc(20, 5, 20, 6, 20, 7, 20, 8);
        do_lock("gap_b");
        setc(18, 1, 18, 2, 18, 3, 18, 4);
        do_lock("gap_c");
        setc(18, 5, 18, 6, 18, 7, 18, 8);
        do_lock("gap_d");
        setc(20, 9, 18, 9, 19, 3, 19, 7);
        do_lock("gap_e");
        setc(20, 10, 18, 10, 17, 1, 16, 2);
        do_lock("gap_clear");
        chk("gap_row20", grid[20], 10'b0010001000);

        @(negedge clk);
        clear_grid = 1'b1;
        @(negedge clk);
        clear_grid = 1'b0;
        model_clear();
        exp_score = 0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) begin
                lr[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(16, 20);
                lc[i] = $urandom_range(0, 11);
            end
            do_lock("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
